// File: rtl/bus_arbiter_16.sv
// ---------------------------------------------------------------------------
// bus_arbiter_16
// Round-robin arbiter for sixteen requesters sharing one 32-bit bus.
// The bus alternates between IDLE (no owner) and GRANT (one owner). A new
// owner is picked in IDLE by a circular search starting at ptr. After any
// release the bus returns to IDLE for at least one cycle so that it can turn
// around. An owner that has held the bus for MAX_HOLD cycles is preempted
// when another requester is waiting. MAX_HOLD = 0 disables preemption.
//
// Ports
//   clk             in   1   rising-edge clock
//   reset_n         in   1   asynchronous active-low reset
//   req             in  16   request vector, bit i = requester i
//   gnt             out 16   registered one-hot grant, zero when idle
//   sel             out  4   registered bus mux select (owner index),
//                            keeps its last value while idle
//   busy            out  1   registered, high while a grant is active
//   owner_valid_cnt out  8   registered cycles held by the current owner,
//                            saturating at 255
// ---------------------------------------------------------------------------
module bus_arbiter_16 #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] req,
    output logic [15:0] gnt,
    output logic [3:0]  sel,
    output logic        busy,
    output logic [7:0]  owner_valid_cnt
);

    localparam logic [7:0] MAX_HOLD_C = 8'(MAX_HOLD);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  ptr_q,   ptr_d;
    logic [15:0] gnt_q,   gnt_d;
    logic [3:0]  sel_q,   sel_d;
    logic        busy_q,  busy_d;
    logic [7:0]  cnt_q,   cnt_d;

    logic        found_s;
    logic [3:0]  win_s;
    logic [3:0]  cand_s;
    logic        others_s;
    logic        preempt_s;
    logic        release_s;

    // Index to one-hot grant vector.
    function automatic logic [15:0] onehot16(input logic [3:0] idx);
        onehot16 = 16'd1 << idx;
    endfunction

    // Circular priority search: first asserted req bit at or above ptr,
    // wrapping through 15 back to 0. The 4-bit add wraps modulo 16.
    always_comb begin
        found_s = 1'b0;
        win_s   = 4'd0;
        cand_s  = 4'd0;
        for (int i = 0; i < 16; i++) begin
            cand_s = ptr_q + 4'(i);
            if (!found_s && req[cand_s]) begin
                found_s = 1'b1;
                win_s   = cand_s;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Release conditions while an owner holds the bus. Owner drop and
    // preemption collapse into a single release, so ptr advances only once.
    always_comb begin
        others_s  = |(req & ~gnt_q);
        preempt_s = (MAX_HOLD_C != 8'd0) && (cnt_q >= MAX_HOLD_C) && others_s;
        release_s = !req[sel_q] || preempt_s;
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (found_s) begin
                    state_d = ST_GRANT;
                    gnt_d   = onehot16(win_s);
                    sel_d   = win_s;
                    busy_d  = 1'b1;
                    cnt_d   = 8'd1;
                end else begin
                    gnt_d  = 16'd0;
                    busy_d = 1'b0;
                    cnt_d  = 8'd0;
                end
            end
            ST_GRANT: begin
                if (release_s) begin
                    // sel is left alone so the mux keeps its last setting.
                    state_d = ST_IDLE;
                    gnt_d   = 16'd0;
                    busy_d  = 1'b0;
                    cnt_d   = 8'd0;
                    ptr_d   = sel_q + 4'd1;
                end else if (cnt_q != 8'd255) begin
                    cnt_d = cnt_q + 8'd1;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = 16'd0;
                busy_d  = 1'b0;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= 4'd0;
            gnt_q   <= 16'd0;
            sel_q   <= 4'd0;
            busy_q  <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
        end
    end

    assign gnt             = gnt_q;
    assign sel             = sel_q;
    assign busy            = busy_q;
    assign owner_valid_cnt = cnt_q;

endmodule

// File: tb/tb_bus_arbiter_16.sv
// ---------------------------------------------------------------------------
// tb_bus_arbiter_16
// Self-checking bench for bus_arbiter_16 built with MAX_HOLD = 4. A table of
// {req, expected gnt/sel/busy/cnt} records is applied one clock per entry,
// followed by hand-written sequences for rotation, long hold, simultaneous
// drop/preemption and mid-grant reset.
// ---------------------------------------------------------------------------
module tb_bus_arbiter_16;

    logic        clk;
    logic        reset_n;
    logic [15:0] req;
    logic [15:0] gnt;
    logic [3:0]  sel;
    logic        busy;
    logic [7:0]  owner_valid_cnt;

    int n_cmp;
    int n_bad;

    typedef struct {
        logic [15:0] req;
        logic [15:0] gnt;
        logic [3:0]  sel;
        logic        busy;
        logic [7:0]  cnt;
    } vec_t;

    vec_t tbl [16];

    bus_arbiter_16 #(.MAX_HOLD(4)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .req             (req),
        .gnt             (gnt),
        .sel             (sel),
        .busy            (busy),
        .owner_valid_cnt (owner_valid_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare all outputs against expectations as one comparison.
    task automatic check(input string nm, input logic [15:0] eg, input logic [3:0] es,
                         input logic eb, input logic [7:0] ec);
        n_cmp++;
        if (gnt !== eg || sel !== es || busy !== eb || owner_valid_cnt !== ec) begin
            n_bad++;
            $display("FAIL %s: got gnt=%h sel=%0d busy=%b cnt=%0d, want gnt=%h sel=%0d busy=%b cnt=%0d",
                     nm, gnt, sel, busy, owner_valid_cnt, eg, es, eb, ec);
        end
    endtask

    // Drive req, take one rising edge, then check just after it.
    task automatic step(input logic [15:0] r, input string nm, input logic [15:0] eg,
                        input logic [3:0] es, input logic eb, input logic [7:0] ec);
        req = r;
        @(posedge clk);
        #1;
        check(nm, eg, es, eb, ec);
    endtask

    task automatic do_reset();
        req = 16'h0000;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("reset", 16'h0000, 4'd0, 1'b0, 8'd0);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        reset_n = 1'b1;
        req     = 16'h0000;

        //           req       gnt       sel   busy  cnt
        tbl[0]  = '{16'h0001, 16'h0001, 4'd0,  1'b1, 8'd1};
        tbl[1]  = '{16'h0000, 16'h0000, 4'd0,  1'b0, 8'd0};  // release, ptr=1
        tbl[2]  = '{16'h0000, 16'h0000, 4'd0,  1'b0, 8'd0};
        tbl[3]  = '{16'h0011, 16'h0010, 4'd4,  1'b1, 8'd1};  // search from 1
        tbl[4]  = '{16'h0011, 16'h0010, 4'd4,  1'b1, 8'd2};
        tbl[5]  = '{16'h0011, 16'h0010, 4'd4,  1'b1, 8'd3};
        tbl[6]  = '{16'h0011, 16'h0010, 4'd4,  1'b1, 8'd4};
        tbl[7]  = '{16'h0011, 16'h0000, 4'd4,  1'b0, 8'd0};  // preempted, ptr=5
        tbl[8]  = '{16'h0011, 16'h0001, 4'd0,  1'b1, 8'd1};  // wrap to 0
        tbl[9]  = '{16'h0001, 16'h0001, 4'd0,  1'b1, 8'd2};
        tbl[10] = '{16'h0000, 16'h0000, 4'd0,  1'b0, 8'd0};  // ptr=1
        tbl[11] = '{16'h8000, 16'h8000, 4'd15, 1'b1, 8'd1};
        tbl[12] = '{16'h8000, 16'h8000, 4'd15, 1'b1, 8'd2};
        tbl[13] = '{16'h0000, 16'h0000, 4'd15, 1'b0, 8'd0};  // ptr 15+1 -> 0
        tbl[14] = '{16'h8001, 16'h0001, 4'd0,  1'b1, 8'd1};
        tbl[15] = '{16'h0000, 16'h0000, 4'd0,  1'b0, 8'd0};

        do_reset();
        for (int i = 0; i < 16; i++) begin
            step(tbl[i].req, $sformatf("tbl[%0d]", i), tbl[i].gnt, tbl[i].sel,
                 tbl[i].busy, tbl[i].cnt);
        end

        // Wrap after owner 14: ptr=15, req 8001 -> 15 then 0.
        do_reset();
        step(16'h4000, "wrap_g14", 16'h4000, 4'd14, 1'b1, 8'd1);
        step(16'h0000, "wrap_r14", 16'h0000, 4'd14, 1'b0, 8'd0);
        step(16'h8001, "wrap_g15", 16'h8000, 4'd15, 1'b1, 8'd1);
        step(16'h0001, "wrap_r15", 16'h0000, 4'd15, 1'b0, 8'd0);
        step(16'h0001, "wrap_g0",  16'h0001, 4'd0,  1'b1, 8'd1);

        // Full rotation with all requesters active: 4 grant cycles + 1 idle.
        do_reset();
        for (int g = 0; g < 17; g++) begin
            for (int c = 1; c <= 4; c++) begin
                step(16'hFFFF, $sformatf("rot_g%0d_c%0d", g, c), 16'd1 << (g % 16),
                     4'(g % 16), 1'b1, 8'(c));
            end
            step(16'hFFFF, $sformatf("rot_idle%0d", g), 16'h0000, 4'(g % 16), 1'b0, 8'd0);
        end

        // Lone requester keeps the bus past MAX_HOLD.
        do_reset();
        for (int k = 1; k <= 20; k++) begin
            step(16'h0010, $sformatf("hold_%0d", k), 16'h0010, 4'd4, 1'b1, 8'(k));
        end
        step(16'h0000, "hold_rel", 16'h0000, 4'd4, 1'b0, 8'd0);

        // Owner 3 drops in the same cycle preemption fires: single release.
        do_reset();
        step(16'h0008, "drop_g1", 16'h0008, 4'd3, 1'b1, 8'd1);
        step(16'h0008, "drop_g2", 16'h0008, 4'd3, 1'b1, 8'd2);
        step(16'h0008, "drop_g3", 16'h0008, 4'd3, 1'b1, 8'd3);
        step(16'h0008, "drop_g4", 16'h0008, 4'd3, 1'b1, 8'd4);
        step(16'h0020, "drop_rel", 16'h0000, 4'd3, 1'b0, 8'd0);
        step(16'h0020, "drop_g5", 16'h0020, 4'd5, 1'b1, 8'd1);

        // Same, but bits 4 and 5 pending afterwards: ptr=4 must pick 4.
        do_reset();
        step(16'h0008, "ptr_g1", 16'h0008, 4'd3, 1'b1, 8'd1);
        step(16'h0008, "ptr_g2", 16'h0008, 4'd3, 1'b1, 8'd2);
        step(16'h0008, "ptr_g3", 16'h0008, 4'd3, 1'b1, 8'd3);
        step(16'h0008, "ptr_g4", 16'h0008, 4'd3, 1'b1, 8'd4);
        step(16'h0020, "ptr_rel", 16'h0000, 4'd3, 1'b0, 8'd0);
        step(16'h0030, "ptr_g4w", 16'h0010, 4'd4, 1'b1, 8'd1);

        // Asynchronous reset pulse between edges during a grant to 7.
        do_reset();
        step(16'h0080, "rst_g7a", 16'h0080, 4'd7, 1'b1, 8'd1);
        step(16'h0080, "rst_g7b", 16'h0080, 4'd7, 1'b1, 8'd2);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_async", 16'h0000, 4'd0, 1'b0, 8'd0);
        #1;
        reset_n = 1'b1;
        step(16'h0081, "rst_g0", 16'h0001, 4'd0, 1'b1, 8'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bus_arbiter_16.md
BUS_ARBITER_16 -- requirements
Module: bus_arbiter_16

Interface
REQ-001 Parameter: MAX_HOLD, 8, maximum consecutive grant cycles before preemption when others wait; 0 disables preemption; legal range 0..255.
REQ-002 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-004 Port: req  input  16  request vector; bit i asserted by requester i and held until granted and finished.
REQ-005 Port: gnt  output  16  registered one-hot grant; all-zero when bus idle.
REQ-006 Port: sel  output  4  registered 32-bit bus mux select; equals index of current owner.
REQ-007 Port: busy  output  1  registered; 1 while any grant active.
REQ-008 Port: owner_valid_cnt  output  8  registered count of cycles the current owner has held the grant.

Function
REQ-009 Block SHALL implement two states: IDLE (no grant) and GRANT (one owner).
REQ-010 In IDLE with req != 0, the block SHALL select the first asserted req bit searching circularly from pointer ptr upward (ptr, ptr+1, ..., 15, 0, ..., ptr-1).
REQ-011 The selection SHALL take effect on the next rising edge: gnt one-hot for winner, sel = winner index, busy = 1, owner_valid_cnt = 1, state GRANT; arbitration latency is 1 cycle.
REQ-012 In IDLE with req == 0, the block SHALL remain in IDLE with gnt = 0, busy = 0.
REQ-013 In GRANT, bits of req other than the owner's SHALL NOT affect gnt or sel.
REQ-014 In GRANT, owner_valid_cnt SHALL increment each cycle and saturate at 255.
REQ-015 Release: when req[owner] = 0 at a rising edge in GRANT, the block SHALL go to IDLE: gnt = 0, busy = 0, owner_valid_cnt = 0, ptr = (owner+1) mod 16.
REQ-016 Preemption: with MAX_HOLD != 0, when owner_valid_cnt >= MAX_HOLD and any other req bit is set at a rising edge, the block SHALL release exactly as REQ-015.
REQ-017 With no other req pending, the owner SHALL keep the grant indefinitely regardless of MAX_HOLD.
REQ-018 Owner dropping req in the same cycle preemption triggers SHALL cause a single release (ptr = owner+1, no double advance).
REQ-019 Every release SHALL be followed by at least one IDLE cycle with gnt = 0 (bus turnaround); no back-to-back grants.
REQ-020 sel SHALL hold its last value during IDLE; it changes only when a new grant is issued.
REQ-021 ptr arithmetic SHALL be 4-bit modulo 16 (15+1 wraps to 0).
REQ-022 gnt SHALL never have more than one bit set; gnt[sel] = 1 whenever busy = 1.

Reset
REQ-023 reset_n = 0 SHALL immediately, independent of clk, force state IDLE, gnt = 0, sel = 0, busy = 0, owner_valid_cnt = 0, ptr = 0.
REQ-024 Reset asserted mid-grant SHALL drop the grant immediately; after deassertion arbitration restarts from ptr = 0 on the first rising edge.

Verification
REQ-025 Reset, then req = 16'h0001 -> after one edge gnt = 16'h0001, sel = 0, busy = 1; req = 0 -> next edge gnt = 0, busy = 0, sel stays 0.
REQ-026 MAX_HOLD = 4, req = 16'hFFFF constant -> grants rotate 0,1,...,15,0; each grant lasts 4 cycles followed by 1 IDLE cycle.
REQ-027 Wrap: after owner 14 releases (ptr = 15), req = 16'h8001 -> gnt = 16'h8000, sel = 15; on its release -> gnt = 16'h0001, sel = 0.
REQ-028 MAX_HOLD = 4, only req = 16'h0010 held 20 cycles -> gnt = 16'h0010 all 20 cycles, owner_valid_cnt reaches 20; no preemption.
REQ-029 Owner 3 holding with count = MAX_HOLD, req[5] set, req[3] dropped same cycle -> single release, ptr = 4, next grant to 5 after one IDLE cycle.
REQ-030 reset_n pulsed low between edges during grant to 7 -> gnt = 0, sel = 0, busy = 0 before next edge; with req = 16'h0081 after release, grant goes to 0.
